vga_sprite_renderer: RTL
========================

// Module: vga_sprite_renderer
// PURPOSE
// - Pixel stage directly downstream of the VGA timing controller. It consumes nextX/nextY plus the blank and sync strobes.
// - Draws one solid rectangular sprite over a background. The sprite bounces off the screen edges.
// - The sprite position updates once per frame, during vertical blanking.
// - Outputs 8-bit RGB to the DAC, with blank and sync delayed to stay pixel-aligned.
// PARAMETERS
// - H_DISPLAY  800       visible width (px)
// - V_DISPLAY  600       visible height (px)
// - BOX_W      64        sprite width (px), 1..H_DISPLAY
// - BOX_H      48        sprite height (px), 1..V_DISPLAY
// - SPEED      4         px moved per frame per axis, 1..63
// - X_INIT     0         reset x of sprite top-left
// - Y_INIT     0         reset y of sprite top-left
// - BOX_RGB    24'hFF0000  sprite colour {R,G,B}
// - BG_RGB     24'h000040  background colour
// - BG_ALT_RGB 24'h202020  alternate background tile colour (CHECKER_BG_EN only)
// PORTS
// - Clock      in   1   pixel clock
// - Reset_n    in   1   asynchronous active-low reset
// - run        in   1   1 = sprite moves each frame; 0 = sprite frozen
// - blank_n_in in   1   from controller, 1 = visible pixel
// - hSync_n_in in   1   from controller
// - vSync_n_in in   1   from controller
// - sync_n_in  in   1   from controller
// - nextX      in   11  pixel x (0 while blanking)
// - nextY      in   10  pixel y (0 while blanking)
// - red        out  8   pixel colour R
// - green      out  8   pixel colour G
// - blue       out  8   pixel colour B
// - blank_n    out  1   blank_n_in delayed 2 cycles
// - hSync_n    out  1   hSync_n_in delayed 2 cycles
// - vSync_n    out  1   vSync_n_in delayed 2 cycles
// - sync_n     out  1   sync_n_in delayed 2 cycles
// - frame_tick out  1   1-cycle pulse on each detected vSync_n_in falling edge
// BEHAVIOUR
// - Reset (async, Reset_n=0):
//   - Outputs: RGB=0, blank_n=0, hSync_n=1, vSync_n=1, sync_n=1, frame_tick=0.
//   - Sprite: xPos=X_INIT, yPos=Y_INIT, dirX=dirY=+1 (right/down).
//   - FSM returns to S_WAIT; vsPrev=1. Asserting reset mid-move aborts the move; no partial update survives.
// - Pipeline, latency exactly 2 clocks from inputs to all outputs:
//   - Stage 1 registers x, y, blank and the three syncs.
//   - Stage 2 computes colour and registers it with the delayed strobes.
// - Colour selection in stage 2:
//   - blank=0 -> RGB=0.
//   - Else, if xPos <= x < xPos+BOX_W and yPos <= y < yPos+BOX_H -> BOX_RGB.
//   - Else -> background colour.
//   - Compare in 12 bits so xPos+BOX_W cannot overflow.
// - frame_tick = vsPrev & ~vSync_n_in. It is registered, so it asserts one cycle after the falling edge.
// - FSM states S_WAIT -> S_MOVE_X -> S_MOVE_Y -> S_WAIT:
//   - S_WAIT leaves only on frame_tick=1 && run=1.
//   - S_MOVE_X and S_MOVE_Y each last 1 cycle.
//   - A frame_tick arriving outside S_WAIT is ignored.
//   - If run=0 at the tick, the FSM stays in S_WAIT and position is unchanged.
// - Axis step for x (y is identical with V_DISPLAY/BOX_H), with MAX = H_DISPLAY-BOX_W:
//   - dirX=+1: if xPos+SPEED >= MAX then xPos=MAX, dirX=-1; else xPos += SPEED.
//   - dirX=-1: if xPos <= SPEED then xPos=0, dirX=+1; else xPos -= SPEED.
//   - Hence xPos never leaves 0..MAX. A reset value beyond MAX is clamped on the first step.
// - Position changes only in vertical blanking, so there is no tearing within a visible frame.
// CONFIGURATION
// - CHECKER_BG_EN defined: background = (x[5]^y[5]) ? BG_ALT_RGB : BG_RGB, i.e. 32x32 px tiles. The sprite still overrides.
// - CHECKER_BG_EN undefined: background = BG_RGB everywhere. BG_ALT_RGB is unused.
// STRUCTURE
// - Package vga_pkg holds:
//   - H_DISPLAY/V_DISPLAY default constants.
//   - typedef rgb_t (struct of three logic [7:0]).
//   - typedef enum logic [1:0] {S_WAIT, S_MOVE_X, S_MOVE_Y} sprite_state_t.
// - Sub-module bounce_axis (parameters LIMIT, SPEED, INIT; ports step_en, pos, dir) is instantiated twice, once per axis.
// - The top level owns the FSM, edge detector and pixel pipeline.
// TESTING
// - Reset: hold Reset_n=0 with random inputs -> RGB=0, blank_n=0, sync outputs=1. Release -> first valid pixel emerges 2 cycles later.
// - Latency: drive blank_n_in=1, nextX=10, nextY=10 at cycle N, sprite at (0,0) -> red=FF, green=00, blue=00 at cycle N+2.
// - Edge: pixel x=64,y=0 with sprite at (0,0) -> BG_RGB. Pixel x=63,y=47 -> BOX_RGB. blank_n_in=0 -> RGB=0.
// - Motion: X_INIT=0, run=1, 3 vSync falling edges -> xPos=12, yPos=12, exactly one frame_tick per edge.
// - Bounce: X_INIT=734, dirX=+1, SPEED=4 -> xPos=736 and dirX=-1; next frame xPos=732. Also Y_INIT=3, dirY=-1 -> yPos=0, dirY=+1.
// - Freeze and abort: run=0 at tick -> position unchanged. Reset_n pulsed in S_MOVE_X -> position=(X_INIT,Y_INIT), state S_WAIT.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_pkg
// Desc     : Shared display constants, pixel colour type and sprite FSM
//            states for the VGA sprite renderer.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_H_DISPLAY = 800;
    localparam int c_V_DISPLAY = 600;

    // Sprite coordinates are compared at this width so pos + size never wraps.
    localparam int c_POS_W = 12;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        S_WAIT,
        S_MOVE_X,
        S_MOVE_Y
    } sprite_state_t;

    function automatic logic in_span(
        input logic [c_POS_W-1:0] base,
        input logic [c_POS_W-1:0] coord,
        input logic [c_POS_W-1:0] len
    );
        return (coord >= base) && (coord < base + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sprite_renderer_bounce_axis.sv
`default_nettype none
// ============================================================================
// Module   : bounce_axis
// Desc     : One axis of sprite motion; steps by SPEED per enable and
//            reflects at 0 and LIMIT, clamping onto the edge it hits.
// Revision : 1.0 - initial release
// ============================================================================
module bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = c_H_DISPLAY - 64,
    parameter int SPEED = 4,
    parameter int INIT  = 0
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               step_en,
    output logic [c_POS_W-1:0] pos,
    output logic               dir
);

    localparam logic [c_POS_W-1:0] c_LIMIT = c_POS_W'(LIMIT);
    localparam logic [c_POS_W-1:0] c_SPEED = c_POS_W'(SPEED);
    localparam logic [c_POS_W-1:0] c_INIT  = c_POS_W'(INIT);

    logic [c_POS_W-1:0] r_pos;
    logic               r_dir;
    logic [c_POS_W-1:0] w_fwd;

    assign w_fwd = r_pos + c_SPEED;

    // r_dir = 1 means moving toward LIMIT.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pos <= c_INIT;
            r_dir <= 1'b1;
        end else if (step_en) begin
            if (r_dir) begin
                if (w_fwd >= c_LIMIT) begin
                    r_pos <= c_LIMIT;
                    r_dir <= 1'b0;
                end else begin
                    r_pos <= w_fwd;
                end
            end else begin
                if (r_pos <= c_SPEED) begin
                    r_pos <= '0;
                    r_dir <= 1'b1;
                end else begin
                    r_pos <= r_pos - c_SPEED;
                end
            end
        end
    end

    assign pos = r_pos;
    assign dir = r_dir;

endmodule
`default_nettype wire

// File: rtl/vga_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_sprite_renderer
// Desc     : Two-stage pixel pipeline drawing one bouncing solid sprite over
//            a background. Define CHECKER_BG_EN for a 32x32 checkered
//            background; otherwise the background is plain BG_RGB.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sprite_renderer
    import vga_pkg::*;
#(
    parameter int          H_DISPLAY  = c_H_DISPLAY,
    parameter int          V_DISPLAY  = c_V_DISPLAY,
    parameter int          BOX_W      = 64,
    parameter int          BOX_H      = 48,
    parameter int          SPEED      = 4,
    parameter int          X_INIT     = 0,
    parameter int          Y_INIT     = 0,
    parameter logic [23:0] BOX_RGB    = 24'hFF0000,
    parameter logic [23:0] BG_RGB     = 24'h000040,
    parameter logic [23:0] BG_ALT_RGB = 24'h202020
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        run,
    input  logic        blank_n_in,
    input  logic        hSync_n_in,
    input  logic        vSync_n_in,
    input  logic        sync_n_in,
    input  logic [10:0] nextX,
    input  logic [9:0]  nextY,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        blank_n,
    output logic        hSync_n,
    output logic        vSync_n,
    output logic        sync_n,
    output logic        frame_tick
);

    localparam logic [1:0] c_S_WAIT   = S_WAIT;
    localparam logic [1:0] c_S_MOVE_X = S_MOVE_X;
    localparam logic [1:0] c_S_MOVE_Y = S_MOVE_Y;

    localparam logic [c_POS_W-1:0] c_BOX_W = c_POS_W'(BOX_W);
    localparam logic [c_POS_W-1:0] c_BOX_H = c_POS_W'(BOX_H);

    // Stage 1
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_blank_s1;
    logic        r_hs_s1;
    logic        r_vs_s1;
    logic        r_sync_s1;

    // Stage 2
    rgb_t        r_rgb;
    logic        r_blank_s2;
    logic        r_hs_s2;
    logic        r_vs_s2;
    logic        r_sync_s2;

    logic        r_vs_prev;
    logic        r_frame_tick;
    logic [1:0]  r_state;

    logic [c_POS_W-1:0] w_xpos;
    logic [c_POS_W-1:0] w_ypos;
    logic [1:0]         w_dir_unused;
    logic               w_step_x;
    logic               w_step_y;
    logic               w_alt;
    logic               w_in_box;
    rgb_t               w_bg;
    rgb_t               w_colour;

    // ------------------------------------------------------------------
    // Frame edge detector and motion sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vs_prev    <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_prev    <= vSync_n_in;
            r_frame_tick <= r_vs_prev & ~vSync_n_in;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_S_WAIT;
        end else begin
            case (r_state)
                c_S_WAIT:   r_state <= (r_frame_tick && run) ? c_S_MOVE_X : c_S_WAIT;
                c_S_MOVE_X: r_state <= c_S_MOVE_Y;
                c_S_MOVE_Y: r_state <= c_S_WAIT;
                default:    r_state <= c_S_WAIT;
            endcase
        end
    end

    assign w_step_x = (r_state == c_S_MOVE_X);
    assign w_step_y = (r_state == c_S_MOVE_Y);

    bounce_axis #(
        .LIMIT (H_DISPLAY - BOX_W),
        .SPEED (SPEED),
        .INIT  (X_INIT)
    ) u_axis_x (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .step_en (w_step_x),
        .pos     (w_xpos),
        .dir     (w_dir_unused[0])
    );

    bounce_axis #(
        .LIMIT (V_DISPLAY - BOX_H),
        .SPEED (SPEED),
        .INIT  (Y_INIT)
    ) u_axis_y (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .step_en (w_step_y),
        .pos     (w_ypos),
        .dir     (w_dir_unused[1])
    );

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_blank_s1 <= 1'b0;
            r_hs_s1    <= 1'b1;
            r_vs_s1    <= 1'b1;
            r_sync_s1  <= 1'b1;
        end else begin
            r_x        <= nextX;
            r_y        <= nextY;
            r_blank_s1 <= blank_n_in;
            r_hs_s1    <= hSync_n_in;
            r_vs_s1    <= vSync_n_in;
            r_sync_s1  <= sync_n_in;
        end
    end

`ifdef CHECKER_BG_EN
    assign w_alt = r_x[5] ^ r_y[5];
`else
    assign w_alt = 1'b0;
`endif

    always_comb begin
        w_bg     = w_alt ? BG_ALT_RGB : BG_RGB;
        w_in_box = in_span(w_xpos, {1'b0, r_x}, c_BOX_W) &&
                   in_span(w_ypos, {2'b00, r_y}, c_BOX_H);
        if (!r_blank_s1) begin
            w_colour = '0;
        end else if (w_in_box) begin
            w_colour = BOX_RGB;
        end else begin
            w_colour = w_bg;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb      <= '0;
            r_blank_s2 <= 1'b0;
            r_hs_s2    <= 1'b1;
            r_vs_s2    <= 1'b1;
            r_sync_s2  <= 1'b1;
        end else begin
            r_rgb      <= w_colour;
            r_blank_s2 <= r_blank_s1;
            r_hs_s2    <= r_hs_s1;
            r_vs_s2    <= r_vs_s1;
            r_sync_s2  <= r_sync_s1;
        end
    end

    assign red        = r_rgb.r;
    assign green      = r_rgb.g;
    assign blue       = r_rgb.b;
    assign blank_n    = r_blank_s2;
    assign hSync_n    = r_hs_s2;
    assign vSync_n    = r_vs_s2;
    assign sync_n     = r_sync_s2;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
